// File: rtl/three_bit_sar_pkg.sv
// Shared types and constants for the 3-bit SAR responder.
package three_bit_sar_pkg;

    // Width of the SAR controller's DAC code.
    localparam int unsigned CODE_W = 3;

    // Code the SAR controller restarts from after adc_reset.
    localparam logic [CODE_W-1:0] RESET_CODE = 3'b011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        CONVERT = 2'd2,
        RESULT  = 2'd3
    } sar_state_t;

endpackage

// File: rtl/sar_cmp_model.sv
// Comparator model: reports whether the held sample lies above the DAC level.
module sar_cmp_model
    import three_bit_sar_pkg::*;
#(
    parameter int unsigned VIN_W = 6
) (
    input  logic [VIN_W-1:0]  hold,
    input  logic [CODE_W-1:0] sel,
    input  logic              enable,
    output logic              add
);

    logic [VIN_W-1:0] dac_level;

    // DAC code occupies the top bits of the sample range.
    assign dac_level = VIN_W'(sel) << (VIN_W - CODE_W);

    // Unsigned compare, forced low outside the enabled window.
    assign add = enable && (hold > dac_level);

endmodule

// File: rtl/three_bit_sar_responder.sv
// Sample-holding responder for an external 3-bit SAR controller.
// Optional feature: define SAR_RESP_CNT_EN to add the conv_count output.
module three_bit_sar_responder
    import three_bit_sar_pkg::*;
#(
    parameter int unsigned VIN_W   = 6,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VIN_W-1:0]  vin,
    input  logic              vin_valid,
    output logic              vin_ready,
    input  logic [CODE_W-1:0] sel,
    input  logic              done,
    output logic              add,
    output logic              adc_reset,
    output logic [CODE_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              timeout
`ifdef SAR_RESP_CNT_EN
    ,
    output logic [7:0]        conv_count
`endif
);

    localparam int unsigned CNT_W = 8;

    sar_state_t        state, state_d;
    logic [VIN_W-1:0]  hold, hold_d;
    logic [CODE_W-1:0] result_d;
    logic              result_valid_d;
    logic              timeout_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
`ifdef SAR_RESP_CNT_EN
    logic [7:0]        conv_count_d;
`endif

    // Comparator sees the held sample only while converting.
    sar_cmp_model #(
        .VIN_W (VIN_W)
    ) u_cmp (
        .hold   (hold),
        .sel    (sel),
        .enable (state == CONVERT),
        .add    (add)
    );

    assign vin_ready = (state == IDLE);
    assign adc_reset = reset || (state == START);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            cnt          <= '0;
`ifdef SAR_RESP_CNT_EN
            conv_count   <= '0;
`endif
        end else begin
            state        <= state_d;
            hold         <= hold_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            timeout      <= timeout_d;
            cnt          <= cnt_d;
`ifdef SAR_RESP_CNT_EN
            conv_count   <= conv_count_d;
`endif
        end
    end

    // Next-state and next-datapath logic; done wins over the timeout abort.
    always_comb begin
        state_d        = state;
        hold_d         = hold;
        result_d       = result;
        result_valid_d = result_valid;
        timeout_d      = 1'b0;
        cnt_d          = cnt;
`ifdef SAR_RESP_CNT_EN
        conv_count_d   = conv_count;
`endif
        case (state)
            IDLE: begin
                if (vin_valid) begin
                    hold_d  = vin;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = CONVERT;
            end
            CONVERT: begin
                if (done) begin
                    result_d       = sel;
                    result_valid_d = 1'b1;
                    state_d        = RESULT;
                end else if ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RESULT: begin
                if (result_valid && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
`ifdef SAR_RESP_CNT_EN
                    conv_count_d   = conv_count + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_three_bit_sar_responder.sv
// Bench for three_bit_sar_responder with a behavioural 3-bit SAR controller attached.
module tb_three_bit_sar_responder;
    import three_bit_sar_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] vin;
    logic       vin_valid;
    logic       vin_ready;
    logic [2:0] sel;
    logic       done;
    logic       add;
    logic       adc_reset;
    logic [2:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       timeout;
`ifdef SAR_RESP_CNT_EN
    logic [7:0] conv_count;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_result = 3'd0;
    int         exp_cnt = 0;
    logic [1:0] done_mode = 2'd0;   // 0: controller, 1: forced low, 2: forced high

    three_bit_sar_responder dut (
        .clk          (clk),
        .reset        (reset),
        .vin          (vin),
        .vin_valid    (vin_valid),
        .vin_ready    (vin_ready),
        .sel          (sel),
        .done         (done),
        .add          (add),
        .adc_reset    (adc_reset),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .timeout      (timeout)
`ifdef SAR_RESP_CNT_EN
        ,
        .conv_count   (conv_count)
`endif
    );

    always #5 clk = ~clk;

    // Controller: step +/-2, then +/-1, then a final +1 only if still low.
    logic [2:0] ctl_code;
    logic [1:0] ctl_phase;
    logic       ctl_done;
    assign ctl_done = (ctl_phase == 2'd3) || ((ctl_phase == 2'd2) && !add);
    assign sel      = ctl_code;
    assign done     = (done_mode == 2'd0) ? ctl_done : (done_mode == 2'd2);

    always @(posedge clk) begin
        if (adc_reset) begin
            ctl_code  <= RESET_CODE;
            ctl_phase <= 2'd0;
        end else if (!ctl_done) begin
            case (ctl_phase)
                2'd0:    ctl_code <= add ? ctl_code + 3'd2 : ctl_code - 3'd2;
                2'd1:    ctl_code <= add ? ctl_code + 3'd1 : ctl_code - 3'd1;
                default: ctl_code <= ctl_code + 3'd1;
            endcase
            ctl_phase <= ctl_phase + 2'd1;
        end
    end

    // Expected code: smallest c with 8*c >= v, saturated at 7.
    function automatic logic [2:0] ref_code(input logic [5:0] v);
        int c;
        c = (int'(v) + 7) / 8;
        if (c > 7) c = 7;
        return 3'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a sample and return one step after the accept edge (START).
    task automatic offer(input logic [5:0] v, input bit push);
        int w = 0;
        while (!vin_ready && w < 30) begin
            tick();
            w++;
        end
        if (!vin_ready) begin
            n_tests++; n_fail++;
            $display("FAIL offer_wait: vin_ready got %0b required 1", vin_ready);
        end
        vin       = v;
        vin_valid = 1'b1;
        tick();
        vin_valid = 1'b0;
        if (push) exp_q.push_back(ref_code(v));
    endtask

    // Wait for a result, compare with the scoreboard, then handshake.
    task automatic finish_result(input string name, input int delay);
        int         w = 0;
        logic [2:0] exp;
        while (!result_valid && w < 30) begin
            tick();
            w++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        n_tests++;
        if (!result_valid) begin
            n_fail++;
            $display("FAIL %s_wait: result_valid got %0b required 1", name, result_valid);
        end else if (result !== exp) begin
            n_fail++;
            $display("FAIL %s_result: got %0d required %0d", name, result, exp);
        end
        last_result = exp;
        repeat (delay) tick();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        exp_cnt++;
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_clear: result_valid got %0b required 0", name, result_valid);
        end
`ifdef SAR_RESP_CNT_EN
        n_tests++;
        if (conv_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s_count: conv_count got %0d required %0d", name, conv_count, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; vin = '0; vin_valid = 1'b0; result_ready = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (adc_reset !== 1'b1) begin
            n_fail++; $display("FAIL reset_adc: adc_reset got %0b required 1", adc_reset);
        end
        n_tests++;
        if ({result_valid, timeout, result, add} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rv=%0b to=%0b result=%0d add=%0b required all 0",
                     result_valid, timeout, result, add);
        end
`ifdef SAR_RESP_CNT_EN
        n_tests++;
        if (conv_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d required 0", conv_count);
        end
`endif
        reset = 1'b0;
        #1;
        n_tests++;
        if ({vin_ready, adc_reset} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: vin_ready=%0b adc_reset=%0b required 1,0", vin_ready, adc_reset);
        end
        tick();
    endtask

    // Directed conversion: check sel/add per CONVERT cycle and result latency.
    task automatic test_trace(input string name, input logic [5:0] v,
                              input logic [11:0] sels, input logic [3:0] adds, input int n);
        offer(v, 1'b1);
        n_tests++;
        if (adc_reset !== 1'b1) begin
            n_fail++; $display("FAIL %s_start: adc_reset got %0b required 1", name, adc_reset);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            n_tests++;
            if (sel !== sels[i*3 +: 3] || add !== adds[i]) begin
                n_fail++;
                $display("FAIL %s_step%0d: sel=%0d add=%0b required sel=%0d add=%0b",
                         name, i, sel, add, sels[i*3 +: 3], adds[i]);
            end
        end
        n_tests++;
        if (result_valid !== 1'b0) begin
            n_fail++; $display("FAIL %s_early: result_valid got %0b required 0", name, result_valid);
        end
        tick();
        n_tests++;
        if (result_valid !== 1'b1 || add !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency: result_valid=%0b add=%0b required 1,0", name, result_valid, add);
        end
        finish_result(name, 0);
    endtask

    task automatic test_timeout();
        int pulses = 0;
        done_mode = 2'd1;
        offer(6'd44, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (timeout) pulses++;
        end
        n_tests++;
        if (pulses != 0 || vin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: pulses=%0d vin_ready=%0b required 0,0", pulses, vin_ready);
        end
        tick();
        n_tests++;
        if (timeout !== 1'b1 || vin_ready !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: to=%0b vin_ready=%0b rv=%0b required 1,1,0",
                     timeout, vin_ready, result_valid);
        end
        n_tests++;
        if (result !== last_result) begin
            n_fail++; $display("FAIL timeout_result: got %0d required %0d", result, last_result);
        end
        tick();
        n_tests++;
        if (timeout !== 1'b0 || vin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_after: to=%0b vin_ready=%0b required 0,1", timeout, vin_ready);
        end
        done_mode = 2'd0;
    endtask

    // done arrives in the very cycle the counter would expire.
    task automatic test_done_priority();
        done_mode = 2'd1;
        offer(6'd44, 1'b1);
        for (int i = 1; i <= 8; i++) tick();
        done_mode = 2'd2;
        tick();
        done_mode = 2'd0;
        n_tests++;
        if (result_valid !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL prio: rv=%0b to=%0b required 1,0", result_valid, timeout);
        end
        finish_result("prio", 1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        int         w = 0;
        offer(6'd40, 1'b0);
        exp = ref_code(6'd40);
        while (!result_valid && w < 30) begin
            tick();
            w++;
        end
        vin = 6'd17; vin_valid = 1'b1; result_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (result !== exp || result_valid !== 1'b1 || vin_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: result=%0d rv=%0b vin_ready=%0b required %0d,1,0",
                         i, result, result_valid, vin_ready, exp);
            end
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        exp_cnt++;
        last_result = exp;
        n_tests++;
        if (result_valid !== 1'b0 || vin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hs: rv=%0b vin_ready=%0b required 0,1", result_valid, vin_ready);
        end
        tick();
        vin_valid = 1'b0;
        exp_q.push_back(ref_code(6'd17));
        n_tests++;
        if (vin_ready !== 1'b0 || adc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: vin_ready=%0b adc_reset=%0b required 0,1", vin_ready, adc_reset);
        end
        finish_result("b2b", 2);
    endtask

    task automatic test_random();
        logic [5:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 6'($urandom_range(0, 63));
            offer(v, 1'b1);
            finish_result($sformatf("rand%0d_v%0d", i, v), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        offer(6'd63, 1'b1);
        void'(exp_q.pop_back());
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (adc_reset !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_adc: adc_reset got %0b required 1", adc_reset);
        end
        tick();
        n_tests++;
        if (vin_ready !== 1'b1 || result_valid !== 1'b0 || result !== 3'd0 || adc_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state: vin_ready=%0b rv=%0b result=%0d adc_reset=%0b required 1,0,0,1",
                     vin_ready, result_valid, result, adc_reset);
        end
        exp_cnt = 0;
        last_result = 3'd0;
`ifdef SAR_RESP_CNT_EN
        n_tests++;
        if (conv_count !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_count: got %0d required 0", conv_count);
        end
`endif
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (timeout || result_valid) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_quiet: spurious cycles got %0d required 0", bad);
        end
        offer(6'd8, 1'b1);
        finish_result("rstmid_after", 0);
    endtask

    initial begin
        test_reset();
        test_trace("v44", 6'd44, {3'd0, 3'd6, 3'd5, 3'd3}, 4'b0011, 3);
        test_trace("v0",  6'd0,  {3'd0, 3'd0, 3'd1, 3'd3}, 4'b0000, 3);
        test_trace("v63", 6'd63, {3'd7, 3'd6, 3'd5, 3'd3}, 4'b1111, 4);
        test_timeout();
        test_done_priority();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/three_bit_sar_responder.md
THREE_BIT_SAR_RESPONDER -- requirements
Module: three_bit_sar_responder

Interface
REQ-001 SHALL have parameter VIN_W, default 6, meaning the width of the held input sample; VIN_W >= 3.
REQ-002 SHALL have parameter TIMEOUT, default 8, meaning the maximum number of CONVERT cycles allowed before abort; range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port vin  input  VIN_W  input sample value.
REQ-006 SHALL have port vin_valid  input  1  sample offered.
REQ-007 SHALL have port vin_ready  output  1  sample accepted when vin_valid is also high.
REQ-008 SHALL have port sel  input  3  current DAC code from the SAR controller.
REQ-009 SHALL have port done  input  1  end-of-conversion flag from the SAR controller.
REQ-010 SHALL have port add  output  1  comparator result to the controller (1 = guess too low).
REQ-011 SHALL have port adc_reset  output  1  restart request to the controller's reset input.
REQ-012 SHALL have port result  output  3  captured conversion code.
REQ-013 SHALL have port result_valid  output  1  result is held and valid.
REQ-014 SHALL have port result_ready  input  1  consumer accepts result.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse when a conversion is aborted.

Function
REQ-016 SHALL implement FSM states IDLE, START, CONVERT and RESULT.
REQ-017 SHALL drive vin_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE when vin_valid=1, latch vin into hold and go to START.
REQ-019 SHALL stay in START for exactly one cycle, drive adc_reset=1, ignore done, then go to CONVERT with the cycle counter cleared.
REQ-020 SHALL make add combinational from hold and sel: add = (hold > {sel, (VIN_W-3) zero bits}), unsigned, in CONVERT only; add=0 in every other state.
REQ-021 SHALL, in CONVERT when done=1 at a posedge, capture sel into result, set result_valid and go to RESULT.
REQ-022 SHALL, in CONVERT, increment the cycle counter each cycle done=0.
REQ-023 SHALL, when the counter reaches TIMEOUT with done=0, pulse timeout for one cycle, leave result unchanged and go to IDLE.
REQ-024 SHALL, in RESULT, hold result and result_valid=1 stable until result_ready=1.
REQ-025 SHALL, on result_valid and result_ready both high, clear result_valid and go to IDLE; new vin SHALL NOT be accepted in that same cycle.
REQ-026 SHALL drive adc_reset = reset OR (state==START).
REQ-027 SHALL give done priority over the timeout condition when both occur in the same cycle.

Reset
REQ-028 SHALL, on reset, go to IDLE and clear hold, result, result_valid, timeout, the counter and conv_count (if present) to 0.
REQ-029 SHALL abort any in-progress conversion on reset with no result_valid or timeout pulse.
REQ-030 SHALL hold adc_reset=1 while reset is high.

Configuration
REQ-031 SHALL, with SAR_RESP_CNT_EN defined, add output port conv_count (8 bits) that increments once per completed result handshake, wraps 255 to 0 and clears on reset.
REQ-032 SHALL, with SAR_RESP_CNT_EN undefined, omit the conv_count port and its logic; all other behaviour is identical.

Structure
REQ-033 SHALL place the state enum typedef, the CODE_W=3 constant and the reset code constant 3'b011 in package three_bit_sar_pkg.
REQ-034 SHALL implement the comparator as sub-module sar_cmp_model, with inputs hold, sel and enable and output add; the remaining logic is the FSM and datapath in the top module.

Verification
REQ-035 SHALL cover: vin=44 with the SAR controller attached -> add sequence 1,1,0 at sel=3,5,6; result=6; result_valid asserted 4 cycles after the accept edge.
REQ-036 SHALL cover: vin=0 -> sel 3,1,0; add stays 0; result=0.
REQ-037 SHALL cover: vin=63 -> sel 3,5,6,7; result=7.
REQ-038 SHALL cover: done held 0 with TIMEOUT=8 -> timeout pulses once, 8 CONVERT cycles after START; state returns to IDLE; vin_ready=1 on the next cycle.
REQ-039 SHALL cover: result_ready held 0 for 5 cycles while vin_valid=1 -> result stays stable and vin_ready stays 0; handshake then completes, and the next vin is accepted one cycle later.
REQ-040 SHALL cover: reset asserted mid-CONVERT -> next cycle state IDLE, result_valid=0, adc_reset=1 during reset; with SAR_RESP_CNT_EN defined, conv_count=0.
